// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, default bit period and parity helper shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int c_DEFAULT_CYCLES_PER_BIT = 434;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_START   = 6'b000010,
        ST_DATA    = 6'b000100,
        ST_PARITY  = 6'b001000,
        ST_STOP    = 6'b010000,
        ST_CLEANUP = 6'b100000
    } uart_state_t;

    // Even parity when odd=0; odd parity inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter, counts 0..c_CYCLES_PER_BIT-1 and ticks on the last cycle of each bit.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_CLR,
    output logic o_TICK
);

    localparam int c_W = $clog2(c_CYCLES_PER_BIT);

    logic [c_W-1:0] r_cnt;

    assign o_TICK = r_cnt == c_W'(c_CYCLES_PER_BIT - 1);

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            r_cnt <= '0;
        else if (i_CLR || o_TICK)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, start/8 data LSB first/stop; define UART_TX_PARITY_EN to add a parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_DEFAULT_CYCLES_PER_BIT
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_BYTE,
    input  logic       i_PARITY,
    output logic       o_TX_SERIAL,
    output logic       o_TX_ACTIVE,
    output logic       o_TX_DONE
);

    uart_state_t r_state, w_next;
    logic [7:0]  r_byte;
    logic [2:0]  r_idx;
    logic        w_tick;
    logic        w_clr;

`ifdef UART_TX_PARITY_EN
    localparam uart_state_t c_AFTER_DATA = ST_PARITY;
    logic r_odd;
    logic w_par;
    assign w_par = parity_bit(r_byte, r_odd);
`else
    localparam uart_state_t c_AFTER_DATA = ST_STOP;
    logic unused_parity;
    assign unused_parity = i_PARITY;
`endif

    assign w_clr = (r_state == ST_IDLE) || (r_state == ST_CLEANUP);

    uart_baud_cnt #(.c_CYCLES_PER_BIT(c_CYCLES_PER_BIT)) u_baud (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_CLR  (w_clr),
        .o_TICK (w_tick)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Any encoding not listed falls to the default and recovers to IDLE.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:    w_next = i_TX_DV ? ST_START : ST_IDLE;
            ST_START:   w_next = w_tick ? ST_DATA : ST_START;
            ST_DATA:    w_next = (w_tick && r_idx == 3'd7) ? c_AFTER_DATA : ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_PARITY:  w_next = w_tick ? ST_STOP : ST_PARITY;
`endif
            ST_STOP:    w_next = w_tick ? ST_CLEANUP : ST_STOP;
            ST_CLEANUP: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_byte <= '0;
            r_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            r_odd  <= 1'b0;
`endif
        end else if (r_state == ST_IDLE) begin
            r_idx <= '0;
            if (i_TX_DV) begin
                r_byte <= i_TX_BYTE;
`ifdef UART_TX_PARITY_EN
                r_odd  <= i_PARITY;
`endif
            end
        end else if (r_state == ST_DATA && w_tick) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    always_comb begin
        o_TX_SERIAL = 1'b1;
        o_TX_ACTIVE = 1'b0;
        o_TX_DONE   = 1'b0;
        case (r_state)
            ST_START: begin
                o_TX_SERIAL = 1'b0;
                o_TX_ACTIVE = 1'b1;
            end
            ST_DATA: begin
                o_TX_SERIAL = r_byte[r_idx];
                o_TX_ACTIVE = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                o_TX_SERIAL = w_par;
                o_TX_ACTIVE = 1'b1;
            end
`endif
            ST_STOP:    o_TX_ACTIVE = 1'b1;
            ST_CLEANUP: o_TX_DONE   = 1'b1;
            default:    o_TX_SERIAL = 1'b1;
        endcase
    end

endmodule
